// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the pipelined memory controller.
package mem_ctrl_pkg;

   // Controller operating state: clearing the array, or serving requests.
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Width of the optional activity counters.
   localparam int STATS_W = 16;

   // Number of byte lanes in a data word.
   function automatic int be_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/mem_ctrl_pipelined_if.sv
// Request/response channel between a bus-side agent and mem_ctrl_pipelined.
interface mem_ctrl_pipelined_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
);
   import mem_ctrl_pkg::*;

   localparam int BE_WIDTH = be_width(DATA_WIDTH);

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [BE_WIDTH-1:0]   req_be;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  rsp_err;
   logic                  wr_err;
   logic                  init_done;

   // Agent side: issues requests, observes responses and status.
   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_data, rsp_err, wr_err, init_done
   );

   // Memory side: accepts requests, returns responses and status.
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_data, rsp_err, wr_err, init_done
   );

endinterface

// File: rtl/mem_rd_pipe.sv
// Read-response delay line: STAGES registers carrying {valid, err, data}.
// Idle stages carry all zeros so the outputs never show stale data.
module mem_rd_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int STAGES     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic                  in_err,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic                  out_err,
   output logic [DATA_WIDTH-1:0] out_data
);

   localparam int SW = DATA_WIDTH + 2;

   logic [SW-1:0] stage_reg [STAGES];

   // Shift the response bundle one stage per clock; reset flushes in-flight reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_reg[i] <= '0;
         end
      end else begin
         stage_reg[0] <= {in_valid, in_err, in_data};
         for (int i = 1; i < STAGES; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign {out_valid, out_err, out_data} = stage_reg[STAGES-1];

endmodule

// File: rtl/mem_ctrl_pipelined.sv
// Single-port memory with valid/ready requests, byte-enabled writes,
// configurable read latency and a post-reset clear engine.
// Optional macro MEM_CTRL_STATS_EN adds saturating rd/wr/err counters.
module mem_ctrl_pipelined
   import mem_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 12,
   parameter int RD_LATENCY = 2
) (
   input logic                clk,
   input logic                reset,
   mem_ctrl_pipelined_if.slave bus
`ifdef MEM_CTRL_STATS_EN
   ,
   output logic [STATS_W-1:0] rd_count,
   output logic [STATS_W-1:0] wr_count,
   output logic [STATS_W-1:0] err_count
`endif
);

   localparam int BE_WIDTH = be_width(DATA_WIDTH);
   localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_t                state_reg;
   logic [IDX_W-1:0]      init_ptr_reg;
   logic [DATA_WIDTH-1:0] mem_array [DEPTH];

   logic                  acc;
   logic                  acc_rd;
   logic                  acc_wr;
   logic                  addr_oor;
   logic [IDX_W-1:0]      word_idx;
   logic [DATA_WIDTH-1:0] rd_word;

   assign acc      = bus.req_valid && bus.req_ready;
   assign acc_rd   = acc && !bus.req_write;
   assign acc_wr   = acc && bus.req_write;
   assign addr_oor = int'(bus.req_addr) >= DEPTH;
   // In-range addresses always fit in IDX_W bits; out-of-range ones never reach the array.
   assign word_idx = bus.req_addr[IDX_W-1:0];
   assign rd_word  = (acc_rd && !addr_oor) ? mem_array[word_idx] : '0;

   // Control FSM: sweep the clear pointer once, then serve requests until reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= INIT;
         init_ptr_reg  <= '0;
         bus.req_ready <= 1'b0;
         bus.init_done <= 1'b0;
      end else begin
         case (state_reg)
            INIT: begin
               init_ptr_reg <= init_ptr_reg + 1'b1;
               if (init_ptr_reg == LAST_IDX) begin
                  state_reg     <= RUN;
                  bus.req_ready <= 1'b1;
                  bus.init_done <= 1'b1;
               end
            end
            RUN: begin
               bus.req_ready <= 1'b1;
               bus.init_done <= 1'b1;
            end
            default: begin
               state_reg     <= INIT;
               init_ptr_reg  <= '0;
               bus.req_ready <= 1'b0;
               bus.init_done <= 1'b0;
            end
         endcase
      end
   end

   // Array write port: zero-fill while clearing, byte-masked writes while running.
   always_ff @(posedge clk) begin
      if (state_reg == INIT) begin
         mem_array[init_ptr_reg] <= '0;
      end else if (acc_wr && !addr_oor) begin
         for (int b = 0; b < BE_WIDTH; b++) begin
            if (bus.req_be[b]) begin
               mem_array[word_idx][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
            end
         end
      end
   end

   // One-cycle flag for a write that targeted an unimplemented word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.wr_err <= 1'b0;
      end else begin
         bus.wr_err <= acc_wr && addr_oor;
      end
   end

   mem_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGES     (RD_LATENCY)
   ) u_rd_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (acc_rd),
      .in_err    (acc_rd && addr_oor),
      .in_data   (rd_word),
      .out_valid (bus.rsp_valid),
      .out_err   (bus.rsp_err),
      .out_data  (bus.rsp_data)
   );

`ifdef MEM_CTRL_STATS_EN
   // Saturating activity counters, cleared by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_count  <= '0;
         wr_count  <= '0;
         err_count <= '0;
      end else begin
         if (acc_rd && rd_count != '1) begin
            rd_count <= rd_count + 1'b1;
         end
         if (acc_wr && wr_count != '1) begin
            wr_count <= wr_count + 1'b1;
         end
         if (acc && addr_oor && err_count != '1) begin
            err_count <= err_count + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_ctrl_pipelined.sv
// Self-checking bench for mem_ctrl_pipelined: directed scenarios plus random
// traffic, checked every cycle against a word-array / response-queue model.
module tb_mem_ctrl_pipelined;

   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 12;
   localparam int LAT   = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   mem_ctrl_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef MEM_CTRL_STATS_EN
   logic [15:0] rd_count, wr_count, err_count;
   int m_rd, m_wr, m_err;
`endif

   mem_ctrl_pipelined #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .RD_LATENCY (LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus)
`ifdef MEM_CTRL_STATS_EN
      ,
      .rd_count  (rd_count),
      .wr_count  (wr_count),
      .err_count (err_count)
`endif
   );

   typedef struct {
      int          due;
      logic [DW-1:0] data;
      logic        err;
   } rsp_t;

   rsp_t        exp_q[$];
   logic [DW-1:0] model_mem [DEPTH];
   int          cyc;
   int          init_cnt;
   int          chk_cnt;
   int          pass_cnt;
   logic        model_ready;
   logic        exp_wr_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
   endtask

   // One clock: drive inputs, advance the model across the edge, check all outputs.
   task automatic tick(input logic rst_v, input logic v, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
      logic acc;
      logic oor;
      rsp_t r;
      logic ev;
      logic [DW-1:0] ed;
      logic eerr;
      reset         = rst_v;
      bus.req_valid = v;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_be    = be;
      acc = v && model_ready && !rst_v;
      oor = int'(a) >= DEPTH;
      exp_wr_err = 1'b0;
      if (rst_v) begin
         exp_q.delete();
         init_cnt    = 0;
         model_ready = 1'b0;
         for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
`ifdef MEM_CTRL_STATS_EN
         m_rd = 0; m_wr = 0; m_err = 0;
`endif
      end else if (acc) begin
`ifdef MEM_CTRL_STATS_EN
         if (w) m_wr++; else m_rd++;
         if (oor) m_err++;
`endif
         if (w) begin
            if (oor) exp_wr_err = 1'b1;
            else for (int b = 0; b < 4; b++)
               if (be[b]) model_mem[a][b*8 +: 8] = d[b*8 +: 8];
         end else begin
            r.due  = cyc + LAT;
            r.data = oor ? '0 : model_mem[a];
            r.err  = oor;
            exp_q.push_back(r);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_v) begin
         init_cnt++;
         if (init_cnt >= DEPTH) model_ready = 1'b1;
      end
      ev = 1'b0; ed = '0; eerr = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         ev = 1'b1; ed = exp_q[0].data; eerr = exp_q[0].err;
         exp_q.delete(0);
      end
      chk("req_ready", 64'(bus.req_ready), 64'(model_ready));
      chk("init_done", 64'(bus.init_done), 64'(model_ready));
      chk("wr_err",    64'(bus.wr_err),    64'(exp_wr_err));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
      chk("rsp_data",  64'(bus.rsp_data),  64'(ed));
      chk("rsp_err",   64'(bus.rsp_err),   64'(eerr));
`ifdef MEM_CTRL_STATS_EN
      chk("rd_count",  64'(rd_count),  64'(m_rd));
      chk("wr_count",  64'(wr_count),  64'(m_wr));
      chk("err_count", 64'(err_count), 64'(m_err));
`endif
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
      tick(1'b0, 1'b1, 1'b1, a, d, be);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      tick(1'b0, 1'b1, 1'b0, a, DW'($urandom), 4'($urandom));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   // Reset, then DEPTH cycles of clearing while junk requests are offered.
   task automatic reset_and_init();
      for (int i = 0; i < 3; i++) tick(1'b1, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), 4'hF);
      for (int i = 0; i < DEPTH; i++)
         tick(1'b0, 1'b1, 1'($urandom), AW'(i), DW'($urandom), 4'hF);
   endtask

   initial begin
      cyc = 0; init_cnt = 0; chk_cnt = 0; pass_cnt = 0;
      model_ready = 1'b0; exp_wr_err = 1'b0;
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
      bus.req_wdata = '0;   bus.req_be = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
`ifdef MEM_CTRL_STATS_EN
      m_rd = 0; m_wr = 0; m_err = 0;
`endif

      reset_and_init();

      // Cleared word reads back as zero.
      rd(4'd5);
      idle(3);

      // Full write then partial byte-enabled overwrite.
      wr(4'd3, 32'hDEADBEEF, 4'b1111);
      wr(4'd3, 32'h11223344, 4'b0101);
      rd(4'd3);
      idle(3);

      // Read immediately after write to the same word.
      wr(4'd7, 32'hA5A5A5A5, 4'b1111);
      rd(4'd7);
      idle(3);

      // Zero byte-enable write is legal and changes nothing.
      wr(4'd7, 32'h0BADF00D, 4'b0000);
      rd(4'd7);
      idle(3);

      // Out-of-range write and reads.
      wr(4'd14, 32'hCAFEF00D, 4'b1111);
      idle(1);
      rd(4'd13);
      rd(4'd15);
      idle(3);

      // Back-to-back reads return in order at full rate.
      wr(4'd0, 32'd1, 4'hF);
      wr(4'd1, 32'd2, 4'hF);
      wr(4'd2, 32'd3, 4'hF);
      wr(4'd3, 32'd4, 4'hF);
      rd(4'd0);
      rd(4'd1);
      rd(4'd2);
      rd(4'd3);
      idle(3);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         tick(1'b0, 1'($urandom_range(0, 9) < 7), 1'($urandom), AW'($urandom),
              DW'($urandom), 4'($urandom));
      idle(4);

      // Reset with two reads in flight; clear must restart from word 0.
      rd(4'd1);
      rd(4'd2);
      reset_and_init();
      for (int i = 0; i < DEPTH; i++) rd(AW'(i));
      idle(4);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
